// File: rtl/fifo_reader.sv
// FIFO read-port to valid/ready stream adapter with a 2-entry skid buffer.
// Optional transfer counter (rd_count) enabled by defining FIFO_READER_CNT_EN.
module fifo_reader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]      rd_count
`endif
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned SUM_W = 3;
    localparam int unsigned CNT_W = 16;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             inflight_q;
    logic             run_q;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             pop;
    logic [SUM_W-1:0] fill;
    logic [OCC_W-1:0] wr_idx;

    assign m_valid = (occ_q != '0);
    assign m_data  = buf0_q;
    assign pop     = m_valid && m_ready;

    // Words owned after this cycle's pop: buffered plus the one still in flight.
    assign fill = SUM_W'(occ_q) + SUM_W'(inflight_q) - SUM_W'(pop);

    // run_q holds off reads until the first edge after reset release.
    assign fifo_rd_en = run_q && !fifo_empty && (fill < SUM_W'(2));

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = OCC_W'(fill);
        wr_idx = OCC_W'(occ_q - OCC_W'(pop));
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (wr_idx == '0) begin
                buf0_d = fifo_rd_data;
            end else begin
                buf1_d = fifo_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            run_q      <= 1'b1;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Free-running transfer count, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(pop);
        end
    end

    assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed scenarios plus random traffic against a
// queue-based model of the upstream FIFO and the expected output stream.
module tb_fifo_reader;

    localparam int unsigned W = 8;

    logic         clk          = 1'b0;
    logic         rst_n        = 1'b1;
    logic         fifo_empty   = 1'b1;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_rd_data = '0;
    logic         m_valid;
    logic         m_ready      = 1'b0;
    logic [W-1:0] m_data;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]  rd_count;
`endif

    fifo_reader #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_count     (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           cyc_n = 0;
    bit           started = 1'b0;
    int           rd_pulses = 0;
    logic [15:0]  n_xfer = '0;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           avail_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: check at negedge, advance the model at posedge.
    task automatic cyc();
        bit           ev;
        bit           er;
        bit           xf;
        logic [W-1:0] w;
        w = '0;
        @(negedge clk);
        ev = (exp_q.size() > 0) && (avail_q[0] <= cyc_n);
        xf = ev && m_ready;
        er = started && rst_n && (fifo_q.size() > 0) && ((exp_q.size() - int'(xf)) < 2);
        chk("m_valid", 32'(m_valid), 32'(ev));
        if (ev) chk("m_data", 32'(m_data), 32'(exp_q[0]));
        else if (!rst_n) chk("m_data_rst", 32'(m_data), 32'(0));
        chk("rd_en", 32'(fifo_rd_en), 32'(er));
`ifdef FIFO_READER_CNT_EN
        chk("rd_count", 32'(rd_count), 32'(n_xfer));
`endif
        if (fifo_rd_en) rd_pulses++;
        @(posedge clk);
        if (xf) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
            n_xfer++;
        end
        if (er) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
            avail_q.push_back(cyc_n + 2);
        end
        started = rst_n;
        cyc_n++;
        #1;
        if (er) fifo_rd_data = w;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
`ifdef FIFO_READER_CNT_EN
        chk("rst_rd_count", 32'(rd_count), 32'(0));
`endif
        exp_q.delete();
        avail_q.delete();
        n_xfer  = '0;
        started = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Idle with empty FIFO, then a single word
        m_ready = 1'b1;
        rd_pulses = 0;
        repeat (20) cyc();
        chk("idle_no_rd", 32'(rd_pulses), 32'(0));
        push(8'hA5);
        repeat (5) cyc();

        // Preloaded burst with m_ready held high
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (8) cyc();
        chk("burst_xfers", 32'(n_xfer), 32'(5));

        // Backpressure: only two words may be fetched
        m_ready = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 4; i++) push(8'(8'h51 + i));
        repeat (10) cyc();
        chk("hold_pulses", 32'(rd_pulses), 32'(2));
        chk("hold_valid", 32'(m_valid), 32'(1));
        chk("hold_data", 32'(m_data), 32'(8'h51));
        m_ready = 1'b1;
        repeat (8) cyc();
        chk("hold_drained", 32'(exp_q.size() + fifo_q.size()), 32'(0));
        chk("hold_xfers", 32'(n_xfer), 32'(9));

        // Alternating ready over eight words
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
        for (int i = 0; i < 24; i++) begin
            m_ready = (i % 2) == 0;
            cyc();
        end
        m_ready = 1'b1;
        repeat (6) cyc();
        chk("toggle_xfers", 32'(n_xfer), 32'(17));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        m_ready = 1'b1;
        repeat (60) cyc();
        chk("rand_drained", 32'(exp_q.size() + fifo_q.size()), 32'(0));

        // Reset with words buffered
        m_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3);
        repeat (5) cyc();
        chk("pre_rst_valid", 32'(m_valid), 32'(1));
        do_reset();
        m_ready = 1'b1;
        push(8'hD1); push(8'hD2);
        repeat (10) cyc();
        chk("post_rst_drained", 32'(exp_q.size() + fifo_q.size()), 32'(0));

`ifdef FIFO_READER_CNT_EN
        // Stream up to the counter wrap point, then three more transfers
        for (int i = 0; i < 70000 && n_xfer != 16'hFFFE; i++) begin
            if (fifo_q.size() < 4) push(8'(i));
            cyc();
        end
        chk("wrap_pre", 32'(rd_count), 32'(16'hFFFE));
        for (int i = 0; i < 10 && n_xfer != 16'h0001; i++) begin
            if (fifo_q.size() < 4) push(8'(i));
            cyc();
        end
        chk("wrap_post", 32'(rd_count), 32'(16'h0001));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
